// File: rtl/servo_access_arbiter_pkg.sv
// Shared constants, FSM encoding and helpers for the servo access arbiter.
package servo_access_arbiter_pkg;

  localparam logic [7:0] SERVO_IDLE_ANGLE = 8'd90;
  localparam logic [7:0] SERVO_MAX_ANGLE  = 8'd180;

  localparam int REQ_EV1 = 0;
  localparam int REQ_EV2 = 1;
  localparam int REQ_P2  = 2;

  localparam logic [0:0] ARB_IDLE    = 1'b0;
  localparam logic [0:0] ARB_GRANTED = 1'b1;

  function automatic logic [7:0] clamp_angle(input logic [7:0] a, input logic [7:0] max_a);
    return (a > max_a) ? max_a : a;
  endfunction

endpackage

// File: rtl/servo_access_arbiter_if.sv
// Requester-side bundle of the servo arbiter, plus the arbiter FSM state for observation.
interface servo_access_arbiter_if #(
  parameter int NUM_REQ = 3
);
  // req is a level request held for as long as the requester wants the servo;
  // grant is registered, one-hot or zero, and follows req with one cycle of latency.
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] angle_in;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           angle_out;
  logic                 settled;
  logic                 busy;
  logic [0:0]           state;

  modport master (
    output req, angle_in,
    input  grant, angle_out, settled, busy, state
  );

  modport slave (
    input  req, angle_in,
    output grant, angle_out, settled, busy, state
  );
endinterface

// File: rtl/servo_slew_limiter.sv
// Moves angle_out one degree toward target every SLEW_DIV cycles; settled is the
// registered equality of angle_out and target.
module servo_slew_limiter
  import servo_access_arbiter_pkg::*;
#(
  parameter int         SLEW_DIV   = 50000,
  parameter logic [7:0] IDLE_ANGLE = SERVO_IDLE_ANGLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] target,
  output logic [7:0] angle_out,
  output logic       settled
);

  localparam int SW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam logic [SW-1:0] WRAP = SW'(SLEW_DIV - 1);

  logic [SW-1:0] slew_cnt;

  // Direction is decided per step from the live target, so a reversal never overshoots.
  always_ff @(posedge clk) begin
    if (rst) begin
      slew_cnt  <= '0;
      angle_out <= IDLE_ANGLE;
      settled   <= 1'b1;
    end else begin
      settled <= (angle_out == target);
      if (slew_cnt == WRAP) begin
        slew_cnt <= '0;
        if (angle_out < target)
          angle_out <= angle_out + 8'd1;
        else if (angle_out > target)
          angle_out <= angle_out - 8'd1;
      end else begin
        slew_cnt <= slew_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/servo_access_arbiter.sv
// Fixed-priority servo arbiter with a minimum-hold guard against preemption thrash,
// feeding a slew limiter that parks the servo at IDLE_ANGLE when nobody holds it.
module servo_access_arbiter
  import servo_access_arbiter_pkg::*;
#(
  parameter int         NUM_REQ      = 3,
  parameter int         SLEW_DIV     = 50000,
  parameter int         MIN_HOLD_CYC = 250000,
  parameter logic [7:0] IDLE_ANGLE   = SERVO_IDLE_ANGLE,
  parameter logic [7:0] MAX_ANGLE    = SERVO_MAX_ANGLE
) (
  input logic                   clk,
  input logic                   rst,
  servo_access_arbiter_if.slave bus
);

  localparam int HW = (MIN_HOLD_CYC > 0) ? $clog2(MIN_HOLD_CYC + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD_CYC);

  logic [0:0]         state, state_d;
  logic [NUM_REQ-1:0] grant, grant_d;
  logic [HW-1:0]      hold_cnt, hold_d;
  logic [NUM_REQ-1:0] req_top;
  logic [NUM_REQ-1:0] higher;
  logic [7:0]         target;
  logic [7:0]         angle_q;
  logic               settled_q;

  // Index 0 is highest priority, so the lowest set bit wins; bits below the one-hot
  // grant are exactly the requesters allowed to preempt it.
  assign req_top = bus.req & (~bus.req + NUM_REQ'(1));
  assign higher  = bus.req & (grant - NUM_REQ'(1));

  always_comb begin
    state_d = state;
    grant_d = grant;
    hold_d  = hold_cnt;
    case (state)
      ARB_IDLE: begin
        if (|bus.req) begin
          state_d = ARB_GRANTED;
          grant_d = req_top;
          hold_d  = HOLD_LOAD;
        end
      end
      default: begin
        if (!(|(bus.req & grant))) begin
          // A release hands over immediately, with no hold check.
          if (|bus.req) begin
            grant_d = req_top;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = ARB_IDLE;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if ((|higher) && (hold_cnt == '0)) begin
          grant_d = req_top;
          hold_d  = HOLD_LOAD;
        end else if (hold_cnt != '0) begin
          hold_d = hold_cnt - HW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      grant    <= grant_d;
      hold_cnt <= hold_d;
    end
  end

  always_comb begin
    target = IDLE_ANGLE;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i])
        target = clamp_angle(bus.angle_in[8*i +: 8], MAX_ANGLE);
    end
  end

  servo_slew_limiter #(
    .SLEW_DIV  (SLEW_DIV),
    .IDLE_ANGLE(IDLE_ANGLE)
  ) u_slew (
    .clk      (clk),
    .rst      (rst),
    .target   (target),
    .angle_out(angle_q),
    .settled  (settled_q)
  );

  assign bus.grant     = grant;
  assign bus.busy      = |grant;
  assign bus.angle_out = angle_q;
  assign bus.settled   = settled_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_servo_access_arbiter.sv
// Bench for servo_access_arbiter: grant-sequence table, directed corner cases and
// randomized traffic compared against a behavioural model.
module tb_servo_access_arbiter;
  import servo_access_arbiter_pkg::*;

  localparam int NUM_REQ  = 3;
  localparam int SLEW_DIV = 4;
  localparam int MIN_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req_v = '0;
  logic [7:0] ang [3];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int m_g;
  int m_age;
  int m_angle;
  int m_phase;
  bit m_settled;

  servo_access_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  assign bus.req      = req_v;
  assign bus.angle_in = {ang[2], ang[1], ang[0]};

  servo_access_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .SLEW_DIV    (SLEW_DIV),
    .MIN_HOLD_CYC(MIN_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_i(input int a);
    return (a > 180) ? 180 : a;
  endfunction

  function automatic int top_req(input logic [2:0] r);
    for (int i = 0; i < 3; i++)
      if (r[i]) return i;
    return -1;
  endfunction

  // Behavioural model: one call per clock edge, using the inputs present before it.
  task automatic model_step();
    int tgt;
    int t;
    if (rst) begin
      m_g = -1; m_age = 0; m_angle = 90; m_phase = 0; m_settled = 1'b1;
      return;
    end
    tgt = (m_g < 0) ? 90 : clamp_i(int'(ang[m_g]));
    m_settled = (m_angle == tgt);
    if (m_phase == SLEW_DIV - 1) begin
      m_phase = 0;
      if (m_angle < tgt) m_angle++;
      else if (m_angle > tgt) m_angle--;
    end else begin
      m_phase++;
    end
    t = top_req(req_v);
    if (m_g < 0) begin
      if (t >= 0) begin m_g = t; m_age = 0; end
    end else if (!req_v[m_g]) begin
      m_g = t; m_age = 0;
    end else if (t < m_g && m_age >= MIN_HOLD) begin
      m_g = t; m_age = 0;
    end else begin
      m_age++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_v = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic int model_grant();
    return (m_g < 0) ? 0 : (1 << m_g);
  endfunction

  // ---------------- grant table ----------------
  typedef struct {
    logic [2:0] req;
    int         ticks;
    logic [2:0] exp_grant;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int n;
    int a_prev;
    bit ok;
    bit above;

    ang[0] = 8'd90; ang[1] = 8'd90; ang[2] = 8'd90;
    do_reset();

    check("reset_grant",   int'(bus.grant), 0);
    check("reset_angle",   int'(bus.angle_out), 90);
    check("reset_settled", int'(bus.settled), 1);
    check("reset_busy",    int'(bus.busy), 0);
    check("reset_state",   int'(bus.state), int'(ARB_IDLE));

    // Arbitration sequence: latency, lower never preempts, release, hold, same-cycle swap.
    vecs[0]  = '{3'b000, 1,  3'b000};
    vecs[1]  = '{3'b001, 1,  3'b001};
    vecs[2]  = '{3'b011, 20, 3'b001};
    vecs[3]  = '{3'b010, 1,  3'b010};
    vecs[4]  = '{3'b110, 3,  3'b010};
    vecs[5]  = '{3'b100, 1,  3'b100};
    vecs[6]  = '{3'b101, 1,  3'b100};
    vecs[7]  = '{3'b101, 6,  3'b100};
    vecs[8]  = '{3'b101, 1,  3'b100};
    vecs[9]  = '{3'b101, 1,  3'b001};
    vecs[10] = '{3'b010, 1,  3'b010};
    vecs[11] = '{3'b001, 1,  3'b001};
    vecs[12] = '{3'b000, 1,  3'b000};

    for (int v = 0; v < 13; v++) begin
      req_v = vecs[v].req;
      for (int k = 0; k < vecs[v].ticks; k++) begin
        tick();
        check($sformatf("vec%0d_grant", v), int'(bus.grant), int'(vecs[v].exp_grant));
        check($sformatf("vec%0d_busy", v), int'(bus.busy), int'(vecs[v].exp_grant != 3'b000));
      end
    end

    // Case 1: single request, ramp 90 -> 100.
    do_reset();
    ang[REQ_P2] = 8'd100;
    req_v = 3'b100;
    tick();
    check("c1_grant", int'(bus.grant), 3'b100);
    n = 0;
    while (bus.angle_out != 8'd100 && n < 80) begin tick(); n++; end
    ok = (n >= 35 && n <= 44);
    check("c1_ramp_cycles_in_range", int'(ok), 1);
    tick(); tick();
    check("c1_settled", int'(bus.settled), 1);
    check("c1_angle", int'(bus.angle_out), 100);

    // Case 2: higher request waits for the hold, then preempts and ramps down.
    do_reset();
    ang[REQ_P2] = 8'd100; ang[REQ_EV1] = 8'd0;
    req_v = 3'b100;
    tick();
    tick(); tick(); tick();
    req_v = 3'b101;
    n = 0;
    ok = 1'b1;
    while (bus.grant != 3'b001 && n < 30) begin
      tick(); n++;
      if (bus.grant != 3'b001 && bus.grant != 3'b100) ok = 1'b0;
    end
    check("c2_grant_only_100_or_001", int'(ok), 1);
    check("c2_preempt_tick", n, 6);
    a_prev = int'(bus.angle_out);
    for (int k = 0; k < 20; k++) tick();
    check("c2_ramping_down", int'(int'(bus.angle_out) < a_prev), 1);

    // Case 4: out-of-range angle clamps at 180.
    do_reset();
    ang[REQ_EV1] = 8'd200;
    req_v = 3'b001;
    above = 1'b0;
    for (int k = 0; k < 420; k++) begin
      tick();
      if (bus.angle_out > 8'd180) above = 1'b1;
    end
    check("c4_never_above_180", int'(above), 0);
    check("c4_angle_180", int'(bus.angle_out), 180);
    check("c4_settled", int'(bus.settled), 1);

    // Case 5: drop all requests mid-ramp, servo parks again.
    do_reset();
    ang[REQ_EV1] = 8'd150;
    req_v = 3'b001;
    n = 0;
    while (bus.angle_out != 8'd120 && n < 300) begin tick(); n++; end
    check("c5_reached_120", int'(bus.angle_out), 120);
    req_v = 3'b000;
    tick();
    check("c5_grant_zero", int'(bus.grant), 0);
    check("c5_busy_zero", int'(bus.busy), 0);
    n = 0;
    while (bus.angle_out != 8'd90 && n < 300) begin tick(); n++; end
    check("c5_parked", int'(bus.angle_out), 90);

    // Case 6: reset mid-ramp.
    do_reset();
    ang[REQ_EV1] = 8'd150;
    req_v = 3'b001;
    n = 0;
    while (bus.angle_out != 8'd130 && n < 300) begin tick(); n++; end
    check("c6_reached_130", int'(bus.angle_out), 130);
    rst = 1'b1;
    tick();
    check("c6_grant", int'(bus.grant), 0);
    check("c6_angle", int'(bus.angle_out), 90);
    check("c6_settled", int'(bus.settled), 1);
    check("c6_busy", int'(bus.busy), 0);
    rst = 1'b0;
    req_v = 3'b000;

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 5) == 0) req_v = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) ang[$urandom_range(0, 2)] = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 499) == 0);
      tick();
      check("rnd_grant",   int'(bus.grant), model_grant());
      check("rnd_busy",    int'(bus.busy), int'(m_g >= 0));
      check("rnd_angle",   int'(bus.angle_out), m_angle);
      check("rnd_settled", int'(bus.settled), int'(m_settled));
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
